// File: rtl/puf_crp_sequencer_pkg.sv
// puf_crp_sequencer_pkg: sequencer state encoding and default PUF geometry.
package puf_crp_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_HI, S_SAMPLE, S_WAIT_LO, S_RESOLVE, S_OUTPUT
  } state_e;
  localparam int unsigned DEF_CH_W = 8;
  localparam logic [7:0] DEF_TAPS = 8'hB8;
endpackage

// File: rtl/puf_crp_sequencer_sync2.sv
// puf_sync2: two-flop synchronizer for the asynchronous PUF arbiter output.
module puf_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end
  assign q_o = sync_q;
endmodule

// File: rtl/puf_crp_sequencer.sv
// puf_crp_sequencer: launches LFSR-stepped challenges into an arbiter PUF,
// majority-votes repeated evaluations and packs the bits into handshaked words.
module puf_crp_sequencer
  import puf_crp_sequencer_pkg::*;
#(
  parameter int unsigned     CH_W   = DEF_CH_W,
  parameter int unsigned     RESP_W = 8,
  parameter int unsigned     NVOTE  = 5,
  parameter int unsigned     SETTLE = 4,
  parameter logic [CH_W-1:0] TAPS   = CH_W'(DEF_TAPS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CH_W-1:0]              seed,
  output logic [CH_W-1:0]              puf_challenge,
  output logic                         puf_pulse,
  input  logic                         puf_resp,
  output logic [RESP_W-1:0]            resp_data,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [$clog2(RESP_W+1)-1:0]  unstable_cnt,
  output logic                         busy
);
  localparam int unsigned UW = $clog2(RESP_W + 1);
  localparam int unsigned VW = $clog2(NVOTE + 1);
  localparam int unsigned SW = $clog2(SETTLE + 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   chal_q, chal_d;
  logic              pulse_q, pulse_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [VW-1:0]     vote_q, vote_d, ones_q, ones_d;
  logic [UW-1:0]     bit_q, bit_d, unst_q, unst_d;
  logic [RESP_W-1:0] shift_q, shift_d, data_q, data_d, shift_nxt;
  logic              valid_q, valid_d, resp_sync, maj;

  puf_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (puf_resp),
    .q_o   (resp_sync)
  );

  assign maj       = ones_q > VW'(NVOTE / 2);
  assign shift_nxt = RESP_W'({shift_q, maj});

  always_comb begin
    state_d  = state_q;
    chal_d   = chal_q;
    pulse_d  = pulse_q;
    settle_d = settle_q;
    vote_d   = vote_q;
    ones_d   = ones_q;
    bit_d    = bit_q;
    unst_d   = unst_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = valid_q;
    case (state_q)
      S_IDLE: if (start) begin
        chal_d  = (seed == '0) ? CH_W'(1) : seed;
        vote_d  = '0;
        ones_d  = '0;
        bit_d   = '0;
        unst_d  = '0;
        shift_d = '0;
        state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        pulse_d  = 1'b1;
        settle_d = SW'(SETTLE - 1);
        state_d  = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        settle_d = settle_q - SW'(1);
        state_d  = (settle_q == '0) ? S_SAMPLE : S_WAIT_HI;
      end
      S_SAMPLE: begin
        ones_d   = ones_q + VW'(resp_sync);
        vote_d   = vote_q + VW'(1);
        pulse_d  = 1'b0;
        settle_d = SW'(SETTLE - 1);
        state_d  = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        settle_d = settle_q - SW'(1);
        state_d  = (settle_q != '0) ? S_WAIT_LO :
                   (vote_q == VW'(NVOTE)) ? S_RESOLVE : S_LAUNCH;
      end
      S_RESOLVE: begin
        shift_d = shift_nxt;
        unst_d  = (ones_q != '0 && ones_q != VW'(NVOTE)) ? unst_q + UW'(1) : unst_q;
        // challenge only steps here, with the launch pulse already low
        chal_d  = {chal_q[CH_W-2:0], ^(chal_q & TAPS)};
        ones_d  = '0;
        vote_d  = '0;
        bit_d   = bit_q + UW'(1);
        if (bit_q == UW'(RESP_W - 1)) begin
          data_d  = shift_nxt;
          valid_d = 1'b1;
          state_d = S_OUTPUT;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_OUTPUT: if (resp_ready) begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      chal_q   <= '0;
      pulse_q  <= 1'b0;
      settle_q <= '0;
      vote_q   <= '0;
      ones_q   <= '0;
      bit_q    <= '0;
      unst_q   <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      chal_q   <= chal_d;
      pulse_q  <= pulse_d;
      settle_q <= settle_d;
      vote_q   <= vote_d;
      ones_q   <= ones_d;
      bit_q    <= bit_d;
      unst_q   <= unst_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign puf_challenge = chal_q;
  assign puf_pulse     = pulse_q;
  assign resp_data     = data_q;
  assign resp_valid    = valid_q;
  assign unstable_cnt  = unst_q;
  assign busy          = state_q != S_IDLE;
endmodule
